// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin sharing of one combinational ALU between two
// requesters (port 0 = EX stage, port 1 = secondary unit). Operands are
// forwarded combinationally to the ALU; the result comes back registered
// one cycle after acceptance with a per-requester response strobe.
// Optional feature macro: ALU_OP_CHECK_EN -- rejects ctrl codes outside
// {000,001,010,110,111}: the op is still accepted, the ALU sees idle values
// and the response carries rsp_result=0, rsp_zero=1, rsp_err=1.
module alu_share_arb #(
   parameter int unsigned WIDTH   = 32,
   parameter logic        RR_INIT = 1'b0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [2:0]       req0_ctrl,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [2:0]       req1_ctrl,
   output logic [WIDTH-1:0] alu_srcA,
   output logic [WIDTH-1:0] alu_srcB,
   output logic [2:0]       alu_ctrl,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   output logic             rsp0_valid,
   output logic             rsp1_valid,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero,
   output logic             rsp_err
);

   // ptr names the requester that wins when both are valid
   logic             ptr;
   logic             gnt0;
   logic             gnt1;
   logic             accept;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;
   logic [2:0]       sel_ctrl;
`ifdef ALU_OP_CHECK_EN
   logic             illegal;
`endif

   // grant selection and handshake; flush or reset suppress acceptance
   always_comb begin
      gnt0       = req0_valid && (!req1_valid || !ptr);
      gnt1       = req1_valid && (!req0_valid ||  ptr);
      req0_ready = gnt0 && reset_n && !flush;
      req1_ready = gnt1 && reset_n && !flush;
      accept     = req0_ready || req1_ready;
   end

   // select the granted requester's operation; idle values when no grant
   always_comb begin
      sel_a    = '0;
      sel_b    = '0;
      sel_ctrl = 3'b000;
      if (gnt0) begin
         sel_a    = req0_a;
         sel_b    = req0_b;
         sel_ctrl = req0_ctrl;
      end else if (gnt1) begin
         sel_a    = req1_a;
         sel_b    = req1_b;
         sel_ctrl = req1_ctrl;
      end
   end

`ifdef ALU_OP_CHECK_EN
   // flag a granted op whose ctrl code the ALU does not implement
   always_comb begin
      illegal = (gnt0 || gnt1) &&
                !(sel_ctrl inside {3'b000, 3'b001, 3'b010, 3'b110, 3'b111});
   end
`endif

   // drive the ALU; rejected ops are replaced by the idle operation
   always_comb begin
      alu_srcA = sel_a;
      alu_srcB = sel_b;
      alu_ctrl = sel_ctrl;
`ifdef ALU_OP_CHECK_EN
      if (illegal) begin
         alu_srcA = '0;
         alu_srcB = '0;
         alu_ctrl = 3'b000;
      end
`endif
   end

   // capture the response, pulse the winner's strobe, rotate the pointer
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ptr        <= RR_INIT;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
      end else begin
         rsp0_valid <= req0_ready;
         rsp1_valid <= req1_ready;
         if (accept) begin
            // winner 0 hands priority to 1, winner 1 hands it back to 0
            ptr        <= req0_ready;
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
`ifdef ALU_OP_CHECK_EN
            if (illegal) begin
               rsp_result <= '0;
               rsp_zero   <= 1'b1;
            end
`endif
         end
      end
   end

`ifdef ALU_OP_CHECK_EN
   // record whether the accepted op was rejected
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rsp_err <= 1'b0;
      end else if (accept) begin
         rsp_err <= illegal;
      end
   end
`else
   assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed-vector bench for alu_share_arb with a small
// behavioural ALU attached to the ALU-facing ports.
module tb_alu_share_arb;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        flush;
   logic        req0_valid, req0_ready;
   logic [31:0] req0_a, req0_b;
   logic [2:0]  req0_ctrl;
   logic        req1_valid, req1_ready;
   logic [31:0] req1_a, req1_b;
   logic [2:0]  req1_ctrl;
   logic [31:0] alu_srcA, alu_srcB;
   logic [2:0]  alu_ctrl;
   logic [31:0] alu_result;
   logic        alu_zero;
   logic        rsp0_valid, rsp1_valid;
   logic [31:0] rsp_result;
   logic        rsp_zero, rsp_err;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   alu_share_arb #(.WIDTH(32), .RR_INIT(1'b0)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .flush      (flush),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_ctrl  (req0_ctrl),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_ctrl  (req1_ctrl),
      .alu_srcA   (alu_srcA),
      .alu_srcB   (alu_srcB),
      .alu_ctrl   (alu_ctrl),
      .alu_result (alu_result),
      .alu_zero   (alu_zero),
      .rsp0_valid (rsp0_valid),
      .rsp1_valid (rsp1_valid),
      .rsp_result (rsp_result),
      .rsp_zero   (rsp_zero),
      .rsp_err    (rsp_err)
   );

   always #5 clk = ~clk;

   // behavioural ALU: AND, OR, ADD, SUB, signed SLT; other codes give 0
   always_comb begin
      case (alu_ctrl)
         3'b000:  alu_result = alu_srcA & alu_srcB;
         3'b001:  alu_result = alu_srcA | alu_srcB;
         3'b010:  alu_result = alu_srcA + alu_srcB;
         3'b110:  alu_result = alu_srcA - alu_srcB;
         3'b111:  alu_result = ($signed(alu_srcA) < $signed(alu_srcB)) ? 32'd1 : 32'd0;
         default: alu_result = '0;
      endcase
      alu_zero = (alu_result == '0);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset held for two cycles with both requesters valid
      reset_n = 1'b0; flush = 1'b0;
      req0_valid = 1'b1; req0_a = 32'd7;          req0_b = 32'd7; req0_ctrl = 3'b110;
      req1_valid = 1'b1; req1_a = 32'hFFFF_FFFF;  req1_b = 32'd2; req1_ctrl = 3'b111;
      tick();
      check("rst_rdy0", 32'(req0_ready), 32'd0);
      check("rst_rdy1", 32'(req1_ready), 32'd0);
      tick();
      check("rst_rsp0", 32'(rsp0_valid), 32'd0);
      check("rst_rsp1", 32'(rsp1_valid), 32'd0);
      check("rst_res",  rsp_result,      32'd0);
      check("rst_zero", 32'(rsp_zero),   32'd0);
      check("rst_err",  32'(rsp_err),    32'd0);

      // contention: 7-7 on port 0, SLT(-1,2) on port 1, grants 0,1,0,1
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("cont_rdy0", 32'(req0_ready), 32'((i % 2) == 0));
         check("cont_rdy1", 32'(req1_ready), 32'((i % 2) == 1));
         tick();
         check("cont_rsp0", 32'(rsp0_valid), 32'((i % 2) == 0));
         check("cont_rsp1", 32'(rsp1_valid), 32'((i % 2) == 1));
         check("cont_res",  rsp_result,      ((i % 2) == 0) ? 32'd0 : 32'd1);
         check("cont_zero", 32'(rsp_zero),   32'((i % 2) == 0));
      end

      // idle cycle: strobes drop, result and zero hold
      req0_valid = 1'b0; req1_valid = 1'b0;
      #1;
      check("idle_alu_a",    alu_srcA,       32'd0);
      check("idle_alu_ctrl", 32'(alu_ctrl),  32'd0);
      tick();
      check("idle_rsp0", 32'(rsp0_valid), 32'd0);
      check("idle_rsp1", 32'(rsp1_valid), 32'd0);
      check("idle_res",  rsp_result,      32'd1);
      check("idle_zero", 32'(rsp_zero),   32'd0);

      // single requester 0: 5+3
      req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_ctrl = 3'b010;
      #1;
      check("single_rdy0",  32'(req0_ready), 32'd1);
      check("single_ctrl",  32'(alu_ctrl),   32'b010);
      check("single_srcA",  alu_srcA,        32'd5);
      check("single_srcB",  alu_srcB,        32'd3);
      tick();
      check("single_rsp0", 32'(rsp0_valid), 32'd1);
      check("single_rsp1", 32'(rsp1_valid), 32'd0);
      check("single_res",  rsp_result,      32'd8);
      check("single_zero", 32'(rsp_zero),   32'd0);

      // back-to-back on requester 1: AND, OR, ADD with no bubbles
      req0_valid = 1'b0;
      req1_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         logic [31:0] exp_res;
         case (k)
            0: begin req1_a = 32'h0000_F0F0; req1_b = 32'h0000_FF00; req1_ctrl = 3'b000; exp_res = 32'h0000_F000; end
            1: begin req1_a = 32'h0000_000F; req1_b = 32'h0000_00F0; req1_ctrl = 3'b001; exp_res = 32'h0000_00FF; end
            default: begin req1_a = 32'd10; req1_b = 32'd20; req1_ctrl = 3'b010; exp_res = 32'd30; end
         endcase
         #1;
         check("b2b_rdy1", 32'(req1_ready), 32'd1);
         tick();
         check("b2b_rsp1", 32'(rsp1_valid), 32'd1);
         check("b2b_rsp0", 32'(rsp0_valid), 32'd0);
         check("b2b_res",  rsp_result,      exp_res);
      end

      // flush with both valid; pointer favours 0 and must not move
      flush = 1'b1;
      req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd4; req0_ctrl = 3'b110;
      req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_ctrl = 3'b010;
      #1;
      check("flush_rdy0",    32'(req0_ready), 32'd0);
      check("flush_rdy1",    32'(req1_ready), 32'd0);
      check("flush_rsp_vis", 32'(rsp1_valid), 32'd1);
      tick();
      check("flush_rsp0", 32'(rsp0_valid), 32'd0);
      check("flush_rsp1", 32'(rsp1_valid), 32'd0);
      check("flush_res",  rsp_result,      32'd30);
      flush = 1'b0;
      #1;
      check("post_flush_rdy0", 32'(req0_ready), 32'd1);
      check("post_flush_rdy1", 32'(req1_ready), 32'd0);
      tick();
      check("post_flush_rsp0", 32'(rsp0_valid), 32'd1);
      check("post_flush_res",  rsp_result,      32'd5);
      #1;
      check("post_flush2_rdy1", 32'(req1_ready), 32'd1);
      tick();
      check("post_flush2_rsp1", 32'(rsp1_valid), 32'd1);
      check("post_flush2_res",  rsp_result,      32'd2);

      // unimplemented ctrl code 011 on requester 0
      req1_valid = 1'b0;
      req0_a = 32'd3; req0_b = 32'd4; req0_ctrl = 3'b011;
      #1;
      check("illeg_rdy0", 32'(req0_ready), 32'd1);
`ifdef ALU_OP_CHECK_EN
      check("illeg_ctrl", 32'(alu_ctrl), 32'b000);
      check("illeg_srcA", alu_srcA,      32'd0);
      tick();
      check("illeg_rsp0", 32'(rsp0_valid), 32'd1);
      check("illeg_err",  32'(rsp_err),    32'd1);
      check("illeg_res",  rsp_result,      32'd0);
      check("illeg_zero", 32'(rsp_zero),   32'd1);
`else
      check("illeg_ctrl", 32'(alu_ctrl), 32'b011);
      check("illeg_srcA", alu_srcA,      32'd3);
      tick();
      check("illeg_rsp0", 32'(rsp0_valid), 32'd1);
      check("illeg_err",  32'(rsp_err),    32'd0);
`endif

      // legal op afterwards clears the error flag: 1|2
      req0_a = 32'd1; req0_b = 32'd2; req0_ctrl = 3'b001;
      tick();
      check("legal_rsp0", 32'(rsp0_valid), 32'd1);
      check("legal_res",  rsp_result,      32'd3);
      check("legal_err",  32'(rsp_err),    32'd0);

      // reset mid-stream discards the transfer and clears all registers
      reset_n = 1'b0;
      #1;
      check("midrst_rdy0", 32'(req0_ready), 32'd0);
      tick();
      check("midrst_rsp0", 32'(rsp0_valid), 32'd0);
      check("midrst_res",  rsp_result,      32'd0);
      check("midrst_zero", 32'(rsp_zero),   32'd0);

      // after release the pointer is back at requester 0
      reset_n = 1'b1;
      req1_valid = 1'b1;
      #1;
      check("rel_rdy0", 32'(req0_ready), 32'd1);
      check("rel_rdy1", 32'(req1_ready), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // both response strobes high together is always an error
   always @(negedge clk) begin
      if (reset_n === 1'b1 && rsp0_valid === 1'b1) begin
         check("rsp_exclusive", 32'(rsp1_valid), 32'd0);
      end
   end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one combinational 32-bit ALU between two requesters. Port 0 is the pipeline EX stage; port 1 is a secondary unit such as address/branch compare.
- Uses a valid/ready handshake per requester, drives the ALU operands and control, and registers the result.
- Returns the result to the winning requester one cycle after acceptance, with a per-requester response strobe.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU.
- RR_INIT, 0, requester favoured by the round-robin pointer after reset (0 or 1).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- flush  in  1  kill in-flight and same-cycle operations
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a  in  WIDTH  requester 0 operand A
- req0_b  in  WIDTH  requester 0 operand B
- req0_ctrl  in  3  requester 0 ALU control code
- req1_valid  in  1  requester 1 has an operation
- req1_ready  out  1  requester 1 operation accepted this cycle
- req1_a  in  WIDTH  requester 1 operand A
- req1_b  in  WIDTH  requester 1 operand B
- req1_ctrl  in  3  requester 1 ALU control code
- alu_srcA  out  WIDTH  operand A to the ALU
- alu_srcB  out  WIDTH  operand B to the ALU
- alu_ctrl  out  3  control code to the ALU
- alu_result  in  WIDTH  ALU result
- alu_zero  in  1  ALU zero flag
- rsp0_valid  out  1  one-cycle pulse: rsp_* belongs to requester 0
- rsp1_valid  out  1  one-cycle pulse: rsp_* belongs to requester 1
- rsp_result  out  WIDTH  registered ALU result
- rsp_zero  out  1  registered zero flag
- rsp_err  out  1  registered illegal-op flag (see Optional Feature)

Behaviour:
- Clocking/reset: one clock, clk. Reset is synchronous and active-low on reset_n, sampled at the rising edge.
- Reset values: rsp0_valid=0, rsp1_valid=0, rsp_result=0, rsp_zero=0, rsp_err=0; priority pointer=RR_INIT.
  - req*_ready is combinational and held at 0 while reset_n=0.
- Grant (combinational, at most one per cycle):
  - Only req0_valid=1: grant 0. Only req1_valid=1: grant 1.
  - Both valid: grant the requester indicated by the pointer.
- reqN_ready=1 only for the granted requester, and only when flush=0 and reset_n=1. A transfer occurs when valid&&ready.
- Pointer: after any transfer, the pointer moves to the other requester (last winner becomes lowest priority). Otherwise it holds.
- ALU drive:
  - With a grant: alu_srcA/alu_srcB/alu_ctrl = the granted requester's a/b/ctrl, passed combinationally.
  - With no grant: alu_srcA=0, alu_srcB=0, alu_ctrl=3'b000, so the ALU never sees X.
- Capture: on a transfer, the next posedge loads rsp_result=alu_result and rsp_zero=alu_zero, and sets rspN_valid=1 for the winner only.
  - Latency is exactly 1 cycle; throughput is 1 operation per cycle.
  - The response is not back-pressured; requesters must consume it in the cycle it is valid.
- No transfer: both rsp*_valid go to 0 next cycle; rsp_result/rsp_zero/rsp_err hold their last values.
- The requester must hold a/b/ctrl stable while valid=1 and ready=0. The arbiter does not latch unaccepted requests.
- Flush (synchronous):
  - When flush=1: no transfer occurs and both rsp*_valid=0 next cycle; rsp_result holds.
  - The pointer does not advance.
  - A response already asserted in the flush cycle stays visible for that cycle.
- reset_n=0 mid-stream: any transfer in that cycle is discarded, and all registers return to their reset values on the next edge.
- rsp0_valid and rsp1_valid are never both 1.

Optional Feature:
- Macro: ALU_OP_CHECK_EN.
- Defined:
  - A granted request whose ctrl is not in {000,001,010,110,111} is still accepted (ready=1, pointer advances).
  - alu_ctrl/alu_srcA/alu_srcB are driven to the idle values (000, 0, 0).
  - Next cycle: rspN_valid=1, rsp_result=0, rsp_zero=1, rsp_err=1.
  - Legal ops produce rsp_err=0.
- Undefined: the ctrl code is forwarded unchanged; rsp_err is a constant 0.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with both valid -> readies 0; all rsp outputs 0 after the edge; first grant after release goes to RR_INIT.
- Single requester: req0 a=5, b=3, ctrl=010 -> req0_ready=1, alu_ctrl=010; next cycle rsp0_valid=1, rsp_result=8, rsp_zero=0, rsp1_valid=0.
- Contention: both valid for 4 cycles, req0 ctrl=110 (7-7) and req1 ctrl=111 (-1,2), with RR_INIT=0 -> grants alternate 0,1,0,1.
  - rsp0 results are 0 with rsp_zero=1; rsp1 results are 1 with rsp_zero=0.
- Back-to-back single requester: req1 valid 3 consecutive cycles (AND, OR, ADD) -> 3 consecutive rsp1_valid pulses with matching results; no bubbles.
- Flush: flush=1 in a cycle where req0 is valid -> req0_ready=0; next cycle no rsp valid; pointer unchanged; the request is served on the following cycle.
- ALU_OP_CHECK_EN defined: req0 ctrl=011 -> accepted; alu_ctrl=000; next cycle rsp0_valid=1, rsp_err=1, rsp_result=0.
  - Undefined: alu_ctrl=011 and rsp_err=0.
